// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared encodings for the multicycle MIPS control.
// AluOp, opcode and funct codes, FSM states and opcode class helpers.
package mips_ctrl_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0100;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b0110;
  localparam logic [3:0] ALU_NOR = 4'b0111;
  localparam logic [3:0] ALU_SLT = 4'b1000;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC_R = 4'd7,
    S_EXEC_I = 4'd8,
    S_ALUWB  = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_HALT   = 4'd12
  } state_t;

  function automatic logic is_mem(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

  function automatic logic is_imm(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_SLTI) || (op == OP_ANDI) ||
           (op == OP_ORI)  || (op == OP_XORI);
  endfunction

  function automatic logic is_br(input logic [5:0] op);
    return (op == OP_BEQ) || (op == OP_BNE);
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: Opcode/Funct/state to AluOp, immediate extension mode
// and an unknown-funct flag; also usable by a single-cycle datapath.
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  state_t      state_i,
  input  logic [5:0]  opcode_i,
  input  logic [5:0]  funct_i,
  output logic [3:0]  aluop_o,
  output logic        imm_zext_o,
  output logic        funct_bad_o
);

  logic [3:0] fn_op;
  logic       fn_ok;
  logic [3:0] im_op;
  logic       im_zx;

  // R-type funct field to ALU function
  always_comb begin
    fn_op = ALU_ADD;
    fn_ok = 1'b1;
    unique case (funct_i)
      FN_ADD:  fn_op = ALU_ADD;
      FN_SUB:  fn_op = ALU_SUB;
      FN_AND:  fn_op = ALU_AND;
      FN_OR:   fn_op = ALU_OR;
      FN_XOR:  fn_op = ALU_XOR;
      FN_NOR:  fn_op = ALU_NOR;
      FN_SLT:  fn_op = ALU_SLT;
      default: fn_ok = 1'b0;
    endcase
  end

  // Immediate opcode to ALU function; logic ops zero-extend
  always_comb begin
    im_op = ALU_ADD;
    im_zx = 1'b0;
    unique case (opcode_i)
      OP_SLTI: im_op = ALU_SLT;
      OP_ANDI: begin im_op = ALU_AND; im_zx = 1'b1; end
      OP_ORI:  begin im_op = ALU_OR;  im_zx = 1'b1; end
      OP_XORI: begin im_op = ALU_XOR; im_zx = 1'b1; end
      default: im_op = ALU_ADD;
    endcase
  end

  // Per-state selection; writeback keeps the execute-stage function
  always_comb begin
    aluop_o     = ALU_ADD;
    imm_zext_o  = 1'b0;
    funct_bad_o = 1'b0;
    unique case (state_i)
      S_EXEC_R: begin
        aluop_o     = fn_op;
        funct_bad_o = ~fn_ok;
      end
      S_EXEC_I: begin
        aluop_o    = im_op;
        imm_zext_o = im_zx;
      end
      S_ALUWB:  aluop_o = (opcode_i == OP_RTYPE) ? fn_op : im_op;
      S_BRANCH: aluop_o = ALU_SUB;
      default:  aluop_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: fetch/decode/execute/memory/writeback sequencer
// for the multicycle MIPS datapath, with memory stall timeout.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       ImmZeroExt,
  output logic [1:0] PCSource,
  output logic [3:0] AluOp,
  output logic       Illegal,
  output logic       MemErr,
  output logic [3:0] State
);

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic TO_EN = (MEM_TIMEOUT != 0);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_q, illegal_d;
  logic             memerr_q, memerr_d;
  logic             stall_st;
  logic             timeout;
  logic             funct_bad;

  alu_decoder u_alu_dec (
    .state_i     (state_q),
    .opcode_i    (Opcode),
    .funct_i     (Funct),
    .aluop_o     (AluOp),
    .imm_zext_o  (ImmZeroExt),
    .funct_bad_o (funct_bad)
  );

  assign State    = state_q;
  assign Illegal  = illegal_q;
  assign MemErr   = memerr_q;
  assign stall_st = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                    (state_q == S_MEMWR);
  assign timeout  = TO_EN && stall_st && !MemReady && (cnt_q == CNT_LAST);

  // Next state, sticky flags and datapath controls
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    memerr_d  = memerr_q;
    PCWrite   = 1'b0;
    IorD      = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    MemtoReg  = 1'b0;
    RegDst    = 1'b0;
    RegWrite  = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    PCSource  = 2'b00;
    unique case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = MemReady;
        PCWrite = MemReady;
        if (MemReady) begin
          state_d = S_DECODE;
        end else if (timeout) begin
          memerr_d = 1'b1;
          state_d  = S_HALT;
        end
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        unique case (1'b1)
          is_mem(Opcode):       state_d = S_MEMADR;
          (Opcode == OP_RTYPE): state_d = S_EXEC_R;
          is_imm(Opcode):       state_d = S_EXEC_I;
          is_br(Opcode):        state_d = S_BRANCH;
          (Opcode == OP_J):     state_d = S_JUMP;
          default: begin
            illegal_d = 1'b1;
            state_d   = S_HALT;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (MemReady) begin
          state_d = S_MEMWB;
        end else if (timeout) begin
          memerr_d = 1'b1;
          state_d  = S_HALT;
        end
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        MemWrite = ~timeout;
        IorD     = 1'b1;
        if (MemReady) begin
          state_d = S_FETCH;
        end else if (timeout) begin
          memerr_d = 1'b1;
          state_d  = S_HALT;
        end
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        if (funct_bad) begin
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          state_d = S_ALUWB;
        end
      end
      S_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = (Opcode == OP_RTYPE);
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        PCSource = 2'b01;
        PCWrite  = (Opcode == OP_BNE) ? ~Zero : Zero;
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        PCSource = 2'b10;
        PCWrite  = 1'b1;
        state_d  = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  // Stall counter: clears on completion or state change, saturates
  always_comb begin
    cnt_d = cnt_q;
    if (MemReady || !stall_st || (state_d != state_q)) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State, stall counter and sticky fault flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      memerr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      memerr_q  <= memerr_d;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: instruction-level reference model producing
// expected per-cycle controls, checked with immediate assertions.
module tb_multicycle_control;
  import mips_ctrl_pkg::*;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] Opcode = '0;
  logic [5:0] Funct = '0;
  logic       Zero = 1'b0;
  logic       MemReady = 1'b0;
  logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg;
  logic       RegDst, RegWrite, ALUSrcA, ImmZeroExt, Illegal, MemErr;
  logic [1:0] ALUSrcB, PCSource;
  logic [3:0] AluOp, State;

  multicycle_control #(.MEM_TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct),
    .Zero(Zero), .MemReady(MemReady), .PCWrite(PCWrite), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmZeroExt(ImmZeroExt),
    .PCSource(PCSource), .AluOp(AluOp), .Illegal(Illegal),
    .MemErr(MemErr), .State(State)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic pcw, iord, mr, mw, irw, m2r, rd, rw, sa;
    logic [1:0] sb;
    logic zx;
    logic [1:0] pcs;
    logic [3:0] op;
    logic ill, merr;
  } cyc_t;

  cyc_t exp_q[$];
  bit   rdy_q[$];
  bit   ill_m, merr_m, halted;
  int   tests = 0;
  int   fails = 0;

  logic [5:0] ops [12] = '{6'b000000, 6'b100011, 6'b101011, 6'b001000,
                           6'b001100, 6'b001101, 6'b001110, 6'b001010,
                           6'b000100, 6'b000101, 6'b000010, 6'b111111};
  logic [5:0] fns [7] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                          6'b100110, 6'b100111, 6'b101010};

  // {valid, AluOp} for an R-type funct
  function automatic logic [4:0] r_lut(input logic [5:0] fn);
    case (fn)
      6'b100000: return {1'b1, 4'b0000};
      6'b100010: return {1'b1, 4'b0001};
      6'b100100: return {1'b1, 4'b0100};
      6'b100101: return {1'b1, 4'b0101};
      6'b100110: return {1'b1, 4'b0110};
      6'b100111: return {1'b1, 4'b0111};
      6'b101010: return {1'b1, 4'b1000};
      default:   return {1'b0, 4'b0000};
    endcase
  endfunction

  // {zero-extend, AluOp} for an immediate opcode
  function automatic logic [4:0] i_lut(input logic [5:0] opc);
    case (opc)
      6'b001010: return {1'b0, 4'b1000};
      6'b001100: return {1'b1, 4'b0100};
      6'b001101: return {1'b1, 4'b0101};
      6'b001110: return {1'b1, 4'b0110};
      default:   return {1'b0, 4'b0000};
    endcase
  endfunction

  function automatic cyc_t mk(input logic [3:0] s);
    cyc_t c;
    c = '0;
    c.st = s;
    c.ill = ill_m;
    c.merr = merr_m;
    return c;
  endfunction

  function automatic cyc_t mem_cyc(input logic [3:0] s, input bit rdy,
                                   input bit last);
    cyc_t c;
    c = mk(s);
    if (s == S_FETCH) begin
      c.mr = 1'b1; c.sb = 2'b01; c.irw = rdy; c.pcw = rdy;
    end else if (s == S_MEMRD) begin
      c.mr = 1'b1; c.iord = 1'b1;
    end else begin
      c.mw = !last; c.iord = 1'b1;
    end
    return c;
  endfunction

  task automatic push(input cyc_t c, input bit r);
    exp_q.push_back(c);
    rdy_q.push_back(r);
  endtask

  task automatic push_halt(input int n);
    halted = 1'b1;
    for (int i = 0; i < n; i++) push(mk(S_HALT), 1'($urandom));
  endtask

  task automatic mem_phase(input logic [3:0] s, input int stalls,
                           output bit ok);
    int n;
    n = (stalls < TO) ? stalls : TO;
    for (int i = 0; i < n; i++) push(mem_cyc(s, 1'b0, i == TO - 1), 1'b0);
    if (stalls >= TO) begin
      merr_m = 1'b1;
      ok = 1'b0;
    end else begin
      push(mem_cyc(s, 1'b1, 1'b0), 1'b1);
      ok = 1'b1;
    end
  endtask

  task automatic chk(input string tag, input cyc_t e);
    cyc_t g;
    g = '{st:State, pcw:PCWrite, iord:IorD, mr:MemRead, mw:MemWrite,
          irw:IRWrite, m2r:MemtoReg, rd:RegDst, rw:RegWrite, sa:ALUSrcA,
          sb:ALUSrcB, zx:ImmZeroExt, pcs:PCSource, op:AluOp,
          ill:Illegal, merr:MemErr};
    tests++;
    assert (g === e) else begin
      fails++;
      $error("FAIL %s state=%0d got=%h exp=%h", tag, e.st, g, e);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    MemReady = 1'($urandom);
    @(posedge clk); #1;
    ill_m = 1'b0;
    merr_m = 1'b0;
    halted = 1'b0;
    chk("reset", mk(S_IDLE));
    reset = 1'b0;
    push(mk(S_IDLE), 1'($urandom));
  endtask

  task automatic drive(input logic [5:0] opc, input logic [5:0] fn,
                       input logic z, input string tag);
    cyc_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      MemReady = rdy_q.pop_front();
      Opcode = opc;
      Funct = fn;
      Zero = z;
      @(negedge clk);
      chk(tag, e);
      @(posedge clk); #1;
    end
  endtask

  task automatic build(input logic [5:0] opc, input logic [5:0] fn,
                       input logic z, input int s0, input int s1);
    bit ok;
    cyc_t c;
    logic [4:0] lu;
    mem_phase(S_FETCH, s0, ok);
    if (!ok) begin push_halt(4); return; end
    c = mk(S_DECODE); c.sb = 2'b11;
    push(c, 1'($urandom));
    if (opc == 6'b000000) begin
      lu = r_lut(fn);
      c = mk(S_EXEC_R); c.sa = 1'b1; c.op = lu[3:0];
      push(c, 1'($urandom));
      if (!lu[4]) begin ill_m = 1'b1; push_halt(3); return; end
      c = mk(S_ALUWB); c.rw = 1'b1; c.rd = 1'b1; c.op = lu[3:0];
      push(c, 1'($urandom));
    end else if (opc inside {6'b001000, 6'b001010, 6'b001100,
                             6'b001101, 6'b001110}) begin
      lu = i_lut(opc);
      c = mk(S_EXEC_I); c.sa = 1'b1; c.sb = 2'b10;
      c.op = lu[3:0]; c.zx = lu[4];
      push(c, 1'($urandom));
      c = mk(S_ALUWB); c.rw = 1'b1; c.op = lu[3:0];
      push(c, 1'($urandom));
    end else if (opc == 6'b100011 || opc == 6'b101011) begin
      c = mk(S_MEMADR); c.sa = 1'b1; c.sb = 2'b10;
      push(c, 1'($urandom));
      if (opc == 6'b100011) begin
        mem_phase(S_MEMRD, s1, ok);
        if (!ok) begin push_halt(3); return; end
        c = mk(S_MEMWB); c.rw = 1'b1; c.m2r = 1'b1;
        push(c, 1'($urandom));
      end else begin
        mem_phase(S_MEMWR, s1, ok);
        if (!ok) begin push_halt(3); return; end
      end
    end else if (opc == 6'b000100 || opc == 6'b000101) begin
      c = mk(S_BRANCH); c.sa = 1'b1; c.op = 4'b0001; c.pcs = 2'b01;
      c.pcw = (opc == 6'b000100) ? z : !z;
      push(c, 1'($urandom));
    end else if (opc == 6'b000010) begin
      c = mk(S_JUMP); c.pcs = 2'b10; c.pcw = 1'b1;
      push(c, 1'($urandom));
    end else begin
      ill_m = 1'b1;
      push_halt(3);
    end
  endtask

  task automatic instr(input logic [5:0] opc, input logic [5:0] fn,
                       input logic z, input int s0, input int s1,
                       input string tag);
    if (halted) do_reset();
    build(opc, fn, z, s0, s1);
    drive(opc, fn, z, tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog tests=%0d", tests);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    cyc_t c;
    logic [5:0] opc, fn;
    int s0, s1;
    halted = 1'b0;
    do_reset();
    instr(6'b000000, 6'b100101, 1'b0, 0, 0, "r_or");
    instr(6'b001110, 6'b010101, 1'b0, 0, 0, "xori");
    instr(6'b000000, 6'b100111, 1'b0, 0, 0, "r_nor");
    instr(6'b100011, 6'b000000, 1'b0, 0, 3, "lw_stall3");
    instr(6'b000100, 6'b000000, 1'b1, 1, 0, "beq_z1");
    instr(6'b000101, 6'b000000, 1'b1, 0, 0, "bne_z1");
    instr(6'b000100, 6'b000000, 1'b0, 0, 0, "beq_z0");
    instr(6'b000101, 6'b000000, 1'b0, 2, 0, "bne_z0");
    instr(6'b101011, 6'b000000, 1'b0, 0, 2, "sw");
    instr(6'b000010, 6'b000000, 1'b0, 0, 0, "j");
    instr(6'b001010, 6'b000000, 1'b0, 3, 0, "slti");
    instr(6'b000000, 6'b000000, 1'b0, 6, 0, "fetch_timeout");
    instr(6'b111111, 6'b000000, 1'b0, 0, 0, "illegal_op");
    instr(6'b000000, 6'b111111, 1'b0, 0, 0, "illegal_fn");
    instr(6'b100011, 6'b000000, 1'b0, 0, 4, "lw_timeout");
    instr(6'b101011, 6'b000000, 1'b0, 0, 7, "sw_timeout");

    // abort a store in its memory stall with an asynchronous reset
    if (halted) do_reset();
    mem_phase(S_FETCH, 0, ok);
    c = mk(S_DECODE); c.sb = 2'b11; push(c, 1'b0);
    c = mk(S_MEMADR); c.sa = 1'b1; c.sb = 2'b10; push(c, 1'b0);
    push(mem_cyc(S_MEMWR, 1'b0, 1'b0), 1'b0);
    push(mem_cyc(S_MEMWR, 1'b0, 1'b0), 1'b0);
    drive(6'b101011, 6'b000000, 1'b0, "sw_pre_abort");
    chk("sw_held", mem_cyc(S_MEMWR, 1'b0, 1'b0));
    reset = 1'b1;
    #1;
    chk("async_abort", mk(S_IDLE));
    @(posedge clk); #1;
    reset = 1'b0;
    push(mk(S_IDLE), 1'($urandom));

    for (int k = 0; k < 80; k++) begin
      opc = ops[$urandom_range(0, 11)];
      fn = ($urandom_range(0, 7) == 0) ? 6'($urandom)
                                       : fns[$urandom_range(0, 6)];
      s0 = ($urandom_range(0, 15) == 0) ? TO + $urandom_range(0, 2)
                                        : $urandom_range(0, 3);
      s1 = ($urandom_range(0, 9) == 0) ? TO + $urandom_range(0, 2)
                                       : $urandom_range(0, 3);
      instr(opc, fn, 1'($urandom), s0, s1, "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
